// File: rtl/prim_buf.sv
// Opaque buffer used to keep otherwise-identical redundant banks from being
// merged by synthesis; technology libraries may replace this with a
// dont_touch cell.
module prim_buf #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  assign out_o = in_i;

endmodule

// File: rtl/prim_sec_redundant_reg.sv
// Redundant (dual or triple) storage register with majority voting,
// mismatch detection, optional scrubbing, a saturating mismatch counter and
// a sticky alert.
module prim_sec_redundant_reg #(
  parameter int unsigned      Width          = 8,
  parameter logic [Width-1:0] ResetValue     = '0,
  parameter int unsigned      NumCopies      = 3,
  parameter bit               ScrubEn        = 1'b1,
  parameter int unsigned      CntWidth       = 4,
  parameter int unsigned      AlertThreshold = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [Width-1:0]    d_i,
  input  logic [Width-1:0]    inj_mask_i,
  output logic [Width-1:0]    q_o,
  output logic                err_o,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic                alert_o
);

  // Scrubbing only makes sense when a majority exists.
  localparam bit                DoScrub  = (NumCopies == 3) && ScrubEn;
  localparam logic [CntWidth-1:0] CntMax   = '1;
  localparam logic [CntWidth-1:0] AlertThr = CntWidth'(AlertThreshold);

  // Buffered bank outputs; all voting and comparison uses these.
  logic [NumCopies-1:0][Width-1:0] copy_buf;
  logic                            scrub;

  assign scrub = DoScrub && err_o && !we_i;

  for (genvar gi = 0; gi < NumCopies; gi++) begin : g_bank
    // Only copy 1 sees the injection mask, so a nonzero mask creates a
    // deliberate single-bank disagreement.
    localparam bit IsInj = (gi == 1);

    logic [Width-1:0] bank_d;
    logic [Width-1:0] bank_q;

    // Next bank value: write beats scrub, otherwise hold.
    always_comb begin
      bank_d = bank_q;
      if (we_i) begin
        bank_d = IsInj ? (d_i ^ inj_mask_i) : d_i;
      end else if (scrub) begin
        bank_d = q_o;
      end
    end

    // Bank storage with asynchronous reset to the reset value.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        bank_q <= ResetValue;
      end else begin
        bank_q <= bank_d;
      end
    end

    prim_buf #(
      .Width (Width)
    ) u_buf (
      .in_i  (bank_q),
      .out_o (copy_buf[gi])
    );
  end

  if (NumCopies == 3) begin : g_vote3
    // Bitwise majority; any pairwise difference implies a disagreement
    // between copy 1 and one of the other two.
    assign q_o   = (copy_buf[0] & copy_buf[1]) |
                   (copy_buf[0] & copy_buf[2]) |
                   (copy_buf[1] & copy_buf[2]);
    assign err_o = (copy_buf[0] != copy_buf[1]) ||
                   (copy_buf[1] != copy_buf[2]);
  end else begin : g_vote2
    // No majority with two copies: copy 0 is authoritative.
    assign q_o   = copy_buf[0];
    assign err_o = (copy_buf[0] != copy_buf[1]);
  end

  logic [CntWidth-1:0] err_cnt_d, err_cnt_q;
  logic                alert_d, alert_q;

  // Saturating mismatch-cycle counter and sticky alert on the next count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_o && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CntWidth'(1);
    end
    alert_d = alert_q || (err_cnt_d >= AlertThr);
  end

  // Counter and alert state; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
      alert_q   <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      alert_q   <= alert_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign alert_o   = alert_q;

endmodule

// File: tb/tb_prim_sec_redundant_reg.sv
// Directed bench for prim_sec_redundant_reg: three configurations share the
// same stimulus (TMR with scrub, dual copy, TMR without scrub with a 2-bit
// counter) and are checked against hand-computed values.
module tb_prim_sec_redundant_reg;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] d;
  logic [7:0] mask;

  // u3: NumCopies=3, ScrubEn=1, CntWidth=4, AlertThreshold=3
  logic [7:0] q3;
  logic       err3;
  logic [3:0] cnt3;
  logic       alert3;
  // u2: NumCopies=2, ResetValue=0x5A, CntWidth=4, AlertThreshold=3
  logic [7:0] q2;
  logic       err2;
  logic [3:0] cnt2;
  logic       alert2;
  // uc: NumCopies=3, ScrubEn=0, CntWidth=2, AlertThreshold=3
  logic [7:0] qc;
  logic       errc;
  logic [1:0] cntc;
  logic       alertc;

  int n_total = 0;
  int n_bad   = 0;

  prim_sec_redundant_reg #(
    .Width(8), .ResetValue(8'h00), .NumCopies(3), .ScrubEn(1'b1),
    .CntWidth(4), .AlertThreshold(3)
  ) u3 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .inj_mask_i(mask),
    .q_o(q3), .err_o(err3), .err_cnt_o(cnt3), .alert_o(alert3)
  );

  prim_sec_redundant_reg #(
    .Width(8), .ResetValue(8'h5A), .NumCopies(2), .ScrubEn(1'b1),
    .CntWidth(4), .AlertThreshold(3)
  ) u2 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .inj_mask_i(mask),
    .q_o(q2), .err_o(err2), .err_cnt_o(cnt2), .alert_o(alert2)
  );

  prim_sec_redundant_reg #(
    .Width(8), .ResetValue(8'h00), .NumCopies(3), .ScrubEn(1'b0),
    .CntWidth(2), .AlertThreshold(3)
  ) uc (
    .clk_i(clk), .rst_i(rst), .we_i(we), .d_i(d), .inj_mask_i(mask),
    .q_o(qc), .err_o(errc), .err_cnt_o(cntc), .alert_o(alertc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clocked transaction; returns 1 time unit after the edge.
  task automatic txn(input logic w, input logic [7:0] dd, input logic [7:0] mm);
    we   = w;
    d    = dd;
    mask = mm;
    @(posedge clk);
    #1;
    $display("txn we=%0b d=%02h mask=%02h | u3 q=%02h e=%0b c=%0d a=%0b | u2 q=%02h e=%0b c=%0d a=%0b | uc q=%02h e=%0b c=%0d a=%0b",
             w, dd, mm, q3, err3, cnt3, alert3, q2, err2, cnt2, alert2,
             qc, errc, cntc, alertc);
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    d    = 8'h00;
    mask = 8'h00;

    // Reset state while reset is held
    #12;
    check_val("rst_q3",     q3,     8'h00);
    check_val("rst_err3",   err3,   1'b0);
    check_val("rst_cnt3",   cnt3,   4'd0);
    check_val("rst_alert3", alert3, 1'b0);
    check_val("rst_q2",     q2,     8'h5A);
    check_val("rst_err2",   err2,   1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean write
    txn(1'b1, 8'hA5, 8'h00);
    check_val("wr_a5_q3",     q3,     8'hA5);
    check_val("wr_a5_err3",   err3,   1'b0);
    check_val("wr_a5_cnt3",   cnt3,   4'd0);
    check_val("wr_a5_alert3", alert3, 1'b0);

    // Injected single-bit fault, then scrub on the idle cycle
    txn(1'b1, 8'h3C, 8'h01);
    check_val("inj_err3", err3, 1'b1);
    check_val("inj_q3",   q3,   8'h3C);
    check_val("inj_cnt3", cnt3, 4'd0);
    check_val("inj_q2",   q2,   8'h3C);
    check_val("inj_err2", err2, 1'b1);
    txn(1'b0, 8'h00, 8'h00);
    check_val("scrub_err3",   err3,   1'b0);
    check_val("scrub_q3",     q3,     8'h3C);
    check_val("scrub_cnt3",   cnt3,   4'd1);
    check_val("scrub_alert3", alert3, 1'b0);
    check_val("noscrub_err2", err2,   1'b1);
    check_val("noscrub_cnt2", cnt2,   4'd1);
    check_val("noscrub_errc", errc,   1'b1);
    check_val("noscrub_qc",   qc,     8'h3C);

    // Asynchronous reset pulse between edges
    #3 rst = 1'b1;
    #1;
    check_val("arst1_q2",   q2,   8'h5A);
    check_val("arst1_cnt2", cnt2, 4'd0);
    check_val("arst1_err2", err2, 1'b0);
    #1 rst = 1'b0;

    // Held mismatch: count, alert, saturation
    txn(1'b1, 8'h00, 8'h80);
    check_val("hold0_q2",     q2,     8'h00);
    check_val("hold0_err2",   err2,   1'b1);
    check_val("hold0_cnt2",   cnt2,   4'd0);
    check_val("hold0_alert2", alert2, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      txn(1'b0, 8'h00, 8'h00);
      check_val($sformatf("hold%0d_cnt2", i),   cnt2,   4'(i));
      check_val($sformatf("hold%0d_alert2", i), alert2, (i >= 3) ? 1'b1 : 1'b0);
      check_val($sformatf("hold%0d_q2", i),     q2,     8'h00);
      check_val($sformatf("hold%0d_cntc", i),   cntc,   (i >= 3) ? 2'd3 : 2'(i));
      check_val($sformatf("hold%0d_alertc", i), alertc, (i >= 3) ? 1'b1 : 1'b0);
    end

    // Clean write after saturation: counter and alert stay
    txn(1'b1, 8'h11, 8'h00);
    check_val("clean_qc",     qc,     8'h11);
    check_val("clean_errc",   errc,   1'b0);
    check_val("clean_cntc",   cntc,   2'd3);
    check_val("clean_alertc", alertc, 1'b1);
    check_val("clean_cnt2",   cnt2,   4'd7);
    check_val("clean_alert2", alert2, 1'b1);
    check_val("clean_err2",   err2,   1'b0);

    // Asynchronous reset with alert set
    #3 rst = 1'b1;
    #1;
    check_val("arst2_q2",     q2,     8'h5A);
    check_val("arst2_cnt2",   cnt2,   4'd0);
    check_val("arst2_alert2", alert2, 1'b0);
    check_val("arst2_qc",     qc,     8'h00);
    check_val("arst2_cntc",   cntc,   2'd0);
    check_val("arst2_alertc", alertc, 1'b0);
    #1 rst = 1'b0;

    // Write beats scrub
    txn(1'b1, 8'h3C, 8'h01);
    check_val("wbs_pre_err3", err3, 1'b1);
    txn(1'b1, 8'h77, 8'h00);
    check_val("wbs_q3",   q3,   8'h77);
    check_val("wbs_err3", err3, 1'b0);
    check_val("wbs_cnt3", cnt3, 4'd1);
    txn(1'b0, 8'h00, 8'h00);
    check_val("wbs_hold_q3",   q3,   8'h77);
    check_val("wbs_hold_err3", err3, 1'b0);
    check_val("wbs_hold_cnt3", cnt3, 4'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
